// File: rtl/lane_pkg.sv
// Shared definitions for the multi-lane transmit datapath: lane geometry,
// the default idle character, the arbiter state encoding and an idle-word
// builder that replicates the idle character into every byte of the bus.
package lane_pkg;

  localparam int         LANE_W     = 32;
  localparam int         LANE_K     = 4;
  localparam logic [7:0] IDLE_K_DEF = 8'hBC;

  // Widest bus the idle-word builder supports; callers slice the low bits.
  localparam int         MAX_LANS   = 16;
  localparam int         MAX_W      = MAX_LANS * LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Idle word for a bus of 'lans' lanes: the character k in every byte of
  // every active lane, zeros above the bus width.
  function automatic logic [MAX_W-1:0] idle_word(input int lans, input logic [7:0] k);
    logic [MAX_W-1:0] w;
    w = '0;
    for (int b = 0; b < MAX_W / 8; b++) begin
      if (b < lans * LANE_K) begin
        w[b*8 +: 8] = k;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/lane_tx_arb_rr_arb.sv
// Round-robin selector: returns the first requesting index strictly after
// ptr, wrapping modulo NREQ. Purely combinational.
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ candidates starting one past the last winner; first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the scan, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (int'(ptr) + k) % NREQ;
      if (!any && req[c]) begin
        any    = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_tx_arb.sv
// Transmit arbiter for the shared multi-lane link bus. Grants whole packets
// to NREQ sources in round-robin order, enforces GAP_BEATS idle beats after
// every packet, and fills every beat that carries no packet data with the
// idle character so the link never sees undefined data.
module lane_tx_arb
  import lane_pkg::*;
#(
  parameter int         LANS      = 4,
  parameter int         NREQ      = 2,
  parameter int         GAP_BEATS = 1,
  parameter logic [7:0] IDLE_K    = IDLE_K_DEF,
  localparam int        IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int        DW        = LANS * LANE_W,
  localparam int        KW        = LANS * LANE_K
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*DW-1:0]   req_dat,
  input  logic [NREQ*KW-1:0]   req_datk,
  input  logic [NREQ*LANS-1:0] req_datv,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 tx_ready,
  output logic [DW-1:0]        tdat,
  output logic [KW-1:0]        tdatk,
  output logic [LANS-1:0]      tdatv,
  output logic [IW-1:0]        gnt_id,
  output logic                 busy
);

  localparam logic [MAX_W-1:0] IDLE_FULL = idle_word(LANS, IDLE_K);
  localparam logic [DW-1:0]    IDLE_DAT  = IDLE_FULL[DW-1:0];
  localparam logic [3:0]       GAP_LAST  = 4'(GAP_BEATS - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [3:0]      gap_cnt, gap_nxt;
  logic            load_gnt;

  // One-hot copy of gnt_id keeps the ready decode and data mux to AND/OR.
  logic [NREQ-1:0] gnt_oh;

  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  logic [DW-1:0]   sel_dat;
  logic [KW-1:0]   sel_datk;
  logic [LANS-1:0] sel_datv;
  logic            sel_valid;
  logic            sel_last;
  logic            accept;

  logic [DW-1:0]   out_dat;
  logic [KW-1:0]   out_datk;
  logic [LANS-1:0] out_datv;

  rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Only the locked requester may see ready, and only while the link consumes.
  assign req_ready = (state == BUSY && tx_ready) ? gnt_oh : '0;

  // Route the locked requester's beat and handshake bits.
  always_comb begin
    sel_dat  = '0;
    sel_datk = '0;
    sel_datv = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_dat  = req_dat[i*DW +: DW];
        sel_datk = req_datk[i*KW +: KW];
        sel_datv = req_datv[i*LANS +: LANS];
      end
    end
  end

  assign sel_valid = |(req_valid & gnt_oh);
  assign sel_last  = |(req_last & gnt_oh);
  assign accept    = (state == BUSY) && tx_ready && sel_valid;

  // Next state: grant in IDLE, hold the lock until the last beat, then count
  // GAP_BEATS consumed idle beats before arbitrating again.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gap_nxt   = gap_cnt;
    load_gnt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          state_nxt = BUSY;
          load_gnt  = 1'b1;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          ptr_nxt   = gnt_id;
          gap_nxt   = '0;
          state_nxt = (GAP_BEATS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (tx_ready) begin
          if (gap_cnt == GAP_LAST) begin
            gap_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            gap_nxt = gap_cnt + 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: state, round-robin pointer, grant and gap counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      ptr     <= IW'(NREQ - 1);
      gnt_id  <= '0;
      gnt_oh  <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gap_cnt <= gap_nxt;
      busy    <= (state_nxt == BUSY);
      if (load_gnt) begin
        gnt_id <= arb_idx;
        gnt_oh <= arb_gnt;
      end
    end
  end

  // Beat to present next: accepted packet data, otherwise the idle word.
  always_comb begin
    out_dat  = IDLE_DAT;
    out_datk = '1;
    out_datv = '1;
    if (accept) begin
      out_dat  = sel_dat;
      out_datk = sel_datk;
      out_datv = sel_datv;
    end
  end

  // Output register: loads only on beats the link consumes, holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this wide datapath register is reset on purpose: the link must
    // see all-zero data, K-flags and valids for as long as rst is high.
    if (rst) begin
      tdat  <= '0;
      tdatk <= '0;
      tdatv <= '0;
    end else if (tx_ready) begin
      tdat  <= out_dat;
      tdatk <= out_datk;
      tdatv <= out_datv;
    end
  end

endmodule

// File: tb/tb_lane_tx_arb.sv
// Self-checking bench for lane_tx_arb: directed scenarios with literal
// expectations, then randomized traffic against a packet-level model.
module tb_lane_tx_arb;

  localparam int LANS      = 4;
  localparam int NREQ      = 2;
  localparam int GAP_BEATS = 1;
  localparam int IW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DW        = LANS * 32;
  localparam int KW        = LANS * 4;
  localparam logic [DW-1:0] IDLE_DAT = {(LANS * 4){8'hBC}};

  typedef struct packed {
    logic [DW-1:0]   dat;
    logic [KW-1:0]   datk;
    logic [LANS-1:0] datv;
    logic            last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ*DW-1:0]   req_dat;
  logic [NREQ*KW-1:0]   req_datk;
  logic [NREQ*LANS-1:0] req_datv;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_ready;
  logic [DW-1:0]        tdat;
  logic [KW-1:0]        tdatk;
  logic [LANS-1:0]      tdatv;
  logic [IW-1:0]        gnt_id;
  logic                 busy;

  lane_tx_arb #(
    .LANS      (LANS),
    .NREQ      (NREQ),
    .GAP_BEATS (GAP_BEATS),
    .IDLE_K    (8'hBC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_dat   (req_dat),
    .req_datk  (req_datk),
    .req_datv  (req_datv),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_ready  (tx_ready),
    .tdat      (tdat),
    .tdatk     (tdatk),
    .tdatv     (tdatv),
    .gnt_id    (gnt_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Source side: pending beats per requester and whether it offers this cycle.
  beat_t           q [NREQ][$];
  logic [NREQ-1:0] will;
  int              pkt_no [NREQ];

  // Reference model: owner of the link (-1 = none), idle beats still owed
  // after a packet, last winner, and the beat the link should be showing.
  int              m_owner;
  int              m_ptr;
  int              m_gap_left;
  int              m_gnt;
  logic [DW-1:0]   m_dat;
  logic [KW-1:0]   m_datk;
  logic [LANS-1:0] m_datv;

  // Observed history, one entry per clock edge, for literal expectations.
  logic [DW-1:0]   h_dat  [$];
  logic            h_busy [$];
  logic [IW-1:0]   h_gnt  [$];
  logic [NREQ-1:0] h_rdy  [$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_dat();
    logic [DW-1:0] d;
    for (int l = 0; l < LANS; l++) d[l*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [DW-1:0] rep_nib(input logic [3:0] n);
    return {(DW / 4){n}};
  endfunction

  task automatic add_beat(input int r, input logic [DW-1:0] d, input logic [KW-1:0] k,
                          input logic [LANS-1:0] v, input logic l);
    beat_t b;
    b.dat  = d;
    b.datk = k;
    b.datv = v;
    b.last = l;
    q[r].push_back(b);
  endtask

  // Packet of n beats whose data words are nibble patterns first, first+1, ...
  task automatic add_nib_pkt(input int r, input int first, input int n);
    for (int i = 0; i < n; i++) add_beat(r, rep_nib(4'(first + i)), '0, '1, (i == n - 1));
  endtask

  task automatic add_rand_pkt(input int r, input int n);
    for (int i = 0; i < n; i++) add_beat(r, rand_dat(), KW'($urandom), LANS'($urandom), (i == n - 1));
  endtask

  task automatic model_reset();
    m_owner    = -1;
    m_ptr      = NREQ - 1;
    m_gap_left = 0;
    m_gnt      = 0;
    m_dat      = '0;
    m_datk     = '0;
    m_datv     = '0;
  endtask

  // One clock edge of the reference behaviour, from the inputs now applied.
  task automatic model_step();
    logic was_last;
    if (rst) begin
      model_reset();
      return;
    end
    if (tx_ready) begin
      if (m_owner >= 0 && req_valid[m_owner]) begin
        m_dat  = q[m_owner][0].dat;
        m_datk = q[m_owner][0].datk;
        m_datv = q[m_owner][0].datv;
      end else begin
        m_dat  = IDLE_DAT;
        m_datk = '1;
        m_datv = '1;
      end
    end
    if (m_owner >= 0) begin
      if (tx_ready && req_valid[m_owner]) begin
        was_last = q[m_owner][0].last;
        void'(q[m_owner].pop_front());
        if (was_last) begin
          m_ptr      = m_owner;
          m_owner    = -1;
          m_gap_left = GAP_BEATS;
        end
      end
    end else if (m_gap_left > 0) begin
      if (tx_ready) m_gap_left--;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (req_valid[c]) begin
          m_owner = c;
          m_gnt   = c;
          break;
        end
      end
    end
  endtask

  function automatic logic [NREQ-1:0] exp_ready();
    logic [NREQ-1:0] r;
    r = '0;
    if (m_owner >= 0 && tx_ready) r[m_owner] = 1'b1;
    return r;
  endfunction

  task automatic compare();
    check("tdat",      tdat,            m_dat);
    check("tdatk",     DW'(tdatk),      DW'(m_datk));
    check("tdatv",     DW'(tdatv),      DW'(m_datv));
    check("req_ready", DW'(req_ready),  DW'(exp_ready()));
    check("busy",      DW'(busy),       DW'(m_owner >= 0));
    check("gnt_id",    DW'(gnt_id),     DW'(m_gnt));
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (will[i] && q[i].size() > 0) begin
        req_valid[i]              = 1'b1;
        req_dat[i*DW +: DW]       = q[i][0].dat;
        req_datk[i*KW +: KW]      = q[i][0].datk;
        req_datv[i*LANS +: LANS]  = q[i][0].datv;
        req_last[i]               = q[i][0].last;
      end else begin
        req_valid[i]              = 1'b0;
        req_dat[i*DW +: DW]       = rand_dat();
        req_datk[i*KW +: KW]      = KW'($urandom);
        req_datv[i*LANS +: LANS]  = LANS'($urandom);
        req_last[i]               = 1'($urandom);
      end
    end
  endtask

  // One clock: apply inputs, compare at the falling edge, advance the model.
  task automatic cycle();
    drive();
    @(negedge clk);
    compare();
    h_rdy.push_back(req_ready);
    @(posedge clk);
    model_step();
    #1;
    h_dat.push_back(tdat);
    h_busy.push_back(busy);
    h_gnt.push_back(gnt_id);
  endtask

  task automatic clear_hist();
    h_dat.delete();
    h_busy.delete();
    h_gnt.delete();
    h_rdy.delete();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    will = '0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    clear_hist();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int grants [$];
    logic prev;

    rst       = 1'b0;
    tx_ready  = 1'b1;
    will      = '0;
    req_dat   = '0;
    req_datk  = '0;
    req_datv  = '0;
    req_valid = '0;
    req_last  = '0;
    for (int i = 0; i < NREQ; i++) pkt_no[i] = 0;
    model_reset();

    // Reset state, then idle fill from the first loaded beat.
    #1 rst = 1'b1;
    #1;
    check("rst_tdat",  tdat,           '0);
    check("rst_tdatk", DW'(tdatk),     '0);
    check("rst_tdatv", DW'(tdatv),     '0);
    check("rst_ready", DW'(req_ready), '0);
    check("rst_busy",  DW'(busy),      '0);
    cycle();
    cycle();
    rst = 1'b0;
    clear_hist();
    cycle();
    check("idle_tdat",  h_dat[0],   128'hBCBC_BCBC_BCBC_BCBC_BCBC_BCBC_BCBC_BCBC);
    check("idle_tdatk", DW'(tdatk), DW'(16'hFFFF));
    check("idle_tdatv", DW'(tdatv), DW'(4'hF));

    // Requester 0, three beats, link always ready.
    clear_hist();
    add_nib_pkt(0, 1, 3);
    will[0] = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    check("b_grant_beat", h_dat[0], IDLE_DAT);
    check("b_beat1",      h_dat[1], rep_nib(4'h1));
    check("b_beat2",      h_dat[2], rep_nib(4'h2));
    check("b_beat3",      h_dat[3], rep_nib(4'h3));
    check("b_gap",        h_dat[4], IDLE_DAT);
    check("b_gnt",        DW'(h_gnt[0]), '0);
    check("b_busy1",      DW'(h_busy[0]), DW'(1'b1));
    check("b_busy3",      DW'(h_busy[2]), DW'(1'b1));
    check("b_busy_end",   DW'(h_busy[3]), '0);

    // Both requesters continuously offering 2-beat packets.
    do_reset();
    will = '1;
    for (int c = 0; c < 24; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (q[r].size() == 0) begin
          for (int b = 0; b < 2; b++)
            add_beat(r, {LANS{8'(r), 8'(pkt_no[r]), 8'(b), 8'h5A}}, '0, '1, (b == 1));
          pkt_no[r]++;
        end
      end
      cycle();
    end
    prev = 1'b0;
    for (int i = 0; i < h_busy.size(); i++) begin
      if (h_busy[i] && !prev) grants.push_back(int'(h_gnt[i]));
      prev = h_busy[i];
    end
    check("c_npkts", DW'(grants.size() >= 4), DW'(1'b1));
    for (int k = 0; k < 4; k++)
      check($sformatf("c_gnt%0d", k), DW'(grants[k]), DW'(k % NREQ));

    // Link stalls for three cycles in the middle of a packet.
    do_reset();
    add_nib_pkt(0, 4, 4);
    will[0] = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    tx_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    tx_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    check("d_ready_pre", DW'(h_rdy[1]), DW'(2'b01));
    for (int k = 3; k < 6; k++) begin
      check($sformatf("d_hold%0d", k),  h_dat[k],     rep_nib(4'h5));
      check($sformatf("d_stall%0d", k), DW'(h_rdy[k]), '0);
    end
    check("d_beat3", h_dat[6], rep_nib(4'h6));
    check("d_beat4", h_dat[7], rep_nib(4'h7));
    check("d_gap",   h_dat[8], IDLE_DAT);

    // Granted requester 1 pauses while requester 0 waits.
    do_reset();
    add_nib_pkt(1, 8, 3);
    add_nib_pkt(0, 1, 2);
    will = 2'b10;
    for (int c = 0; c < 2; c++) cycle();
    will = 2'b01;
    for (int c = 0; c < 2; c++) cycle();
    will = 2'b11;
    for (int c = 0; c < 6; c++) cycle();
    check("e_gnt1",   DW'(h_gnt[0]), DW'(1));
    check("e_pause1", h_dat[2], IDLE_DAT);
    check("e_pause2", h_dat[3], IDLE_DAT);
    check("e_busy1",  DW'(h_busy[2]), DW'(1'b1));
    check("e_busy2",  DW'(h_busy[3]), DW'(1'b1));
    check("e_beat2",  h_dat[4], rep_nib(4'h9));
    check("e_beat3",  h_dat[5], rep_nib(4'hA));
    for (int k = 0; k < 8; k++)
      check($sformatf("e_rdy0_%0d", k), DW'(h_rdy[k][0]), '0);
    check("e_gnt0",   DW'(h_gnt[7]), '0);
    check("e_rdy0_on", DW'(h_rdy[8][0]), DW'(1'b1));
    check("e_r0beat", h_dat[8], rep_nib(4'h1));

    // Reset pulse in the middle of a 4-beat packet.
    do_reset();
    add_nib_pkt(0, 1, 4);
    will[0] = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    check("f_beat2", h_dat[2], rep_nib(4'h2));
    #2 rst = 1'b1;
    #1;
    check("f_async_tdat",  tdat,           '0);
    check("f_async_tdatk", DW'(tdatk),     '0);
    check("f_async_tdatv", DW'(tdatv),     '0);
    check("f_async_busy",  DW'(busy),      '0);
    check("f_async_ready", DW'(req_ready), '0);
    will = '0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    clear_hist();
    add_nib_pkt(0, 3, 2);
    add_nib_pkt(1, 6, 2);
    will = '1;
    for (int c = 0; c < 12; c++) cycle();
    check("f_first_gnt",  DW'(h_gnt[0]),  '0);
    check("f_first_busy", DW'(h_busy[0]), DW'(1'b1));
    check("f_first_beat", h_dat[1], rep_nib(4'h3));

    // Randomized traffic: random offers, pauses, link stalls and resets.
    clear_hist();
    for (int c = 0; c < 4000; c++) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++) begin
        will[r] = ($urandom_range(0, 4) != 0);
        if (q[r].size() == 0 && $urandom_range(0, 2) == 0)
          add_rand_pkt(r, $urandom_range(1, 4));
      end
      cycle();
      if (c % 1500 == 1499) begin
        do_reset();
        tx_ready = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lane_tx_arb.md
# lane_tx_arb

Transmit-side arbiter for the multi-lane link datapath. Shares the single LANS-lane transmit bus (tdat/tdatk/tdatv, 32 data bits, 4 K-flags and 1 valid per lane) between NREQ packet sources. Grants whole packets in round-robin order and fills every unused beat with K28.5 idle characters, so the link never sees undefined data. Sits between the packet sources and the transmit input of the lane DPI/PHY model.

## Interface
- LANS, 4, number of lanes; bus width is LANS*32
- NREQ, 2, number of requesters, 2..8
- GAP_BEATS, 1, mandatory idle beats between packets, 0..15
- IDLE_K, 8'hBC, idle character (K28.5) replicated into every byte

- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_dat  in  NREQ*LANS*32  per-requester beat data, requester i at slice i
- req_datk  in  NREQ*LANS*4  per-requester K-flags, one per byte
- req_datv  in  NREQ*LANS  per-requester lane valids, one per lane
- req_valid  in  NREQ  beat offered
- req_last  in  NREQ  offered beat is the final beat of its packet
- req_ready  out  NREQ  beat accepted this cycle
- tx_ready  in  1  datapath consumes the output beat this cycle
- tdat  out  LANS*32  transmit data, registered
- tdatk  out  LANS*4  transmit K-flags, registered
- tdatv  out  LANS  transmit lane valids, registered
- gnt_id  out  max(1,$clog2(NREQ))  currently or last granted requester
- busy  out  1  a packet is locked (state BUSY)

## Operation
- States: IDLE, BUSY, GAP. Round-robin pointer ptr holds the last granted index.
- IDLE: if any req_valid, select the first valid index after ptr, wrapping modulo NREQ. Load gnt_id and go to BUSY on the next edge. tx_ready is ignored for this decision.
- BUSY: req_ready[gnt_id] = tx_ready; all other req_ready bits are 0.
  - A beat is accepted when req_valid & req_ready.
  - On an accepted beat with req_last: ptr <= gnt_id, then go to GAP, or go to IDLE if GAP_BEATS=0.
- Lock: the grant holds until the last beat is accepted, even if the granted requester drops valid. No other requester is served meanwhile.
- GAP: a counter counts beats loaded while tx_ready=1. After GAP_BEATS such beats, go to IDLE.
- Output register loads only when tx_ready=1, and holds otherwise:
  - Accepted beat: the requester's dat/datk/datv, passed through unmodified.
  - Any other case (IDLE, GAP, or BUSY with granted valid=0): the idle word. tdat={LANS*4{IDLE_K}}, tdatk all ones, tdatv all ones.
- busy=1 exactly in BUSY.
- Reset values: tdat=0, tdatk=0, tdatv=0, req_ready=0, busy=0, gnt_id=0, state IDLE, ptr=NREQ-1 so requester 0 wins first, gap counter 0.

## Timing
- req_ready is combinational from state, gnt_id and tx_ready. No other output is combinational.
- Grant latency: req_valid first high in IDLE at edge t → BUSY and req_ready at t+1.
- Data latency: beat accepted at edge t appears on tdat after edge t, so it is consumed at t+1.
- tx_ready=0: no acceptance, output holds, GAP counter frozen.
- Simultaneous last-accept and new requests: the new grant takes effect only after GAP completes. ptr is already updated, so the next requester in order wins.
- Reset assertion mid-packet: outputs clear immediately. The packet is dropped and no resume occurs after release.

## Structure
- Package lane_pkg:
  - LANE_W=32, LANE_K=4, IDLE_K_DEF=8'hBC
  - state enum {IDLE, BUSY, GAP}
  - function idle_word(LANS)
- Sub-module rr_arb (NREQ): inputs req vector and ptr, outputs one-hot grant, index and any. Purely combinational.
- Top-level file: FSM, gap counter, output register, req_ready decode.

## Test plan
- Reset, then no requests with tx_ready=1: outputs 0 during reset. From the first loaded beat: tdat=128'hBCBC…BC, tdatk=16'hFFFF, tdatv=4'hF.
- Requester 0 sends 3 beats 128'h1…1, 128'h2…2, 128'h3…3 (last on 3rd), tx_ready=1: the three beats appear on consecutive cycles, followed by exactly 1 idle beat. gnt_id=0, busy high for 3 accepted cycles.
- Both requesters continuously offer 2-beat packets: gnt_id sequence 0,1,0,1, each packet separated by exactly GAP_BEATS=1 idle beat. No interleaving of beats.
- tx_ready low for 3 cycles mid-packet: tdat holds its value and req_ready=0. After release the remaining beats continue with none lost or duplicated.
- Granted requester 1 drops valid for 2 cycles mid-packet while requester 0 is valid: 2 idle beats are inserted and busy stays 1. req_ready[0]=0 until requester 1's last beat plus the gap.
- rst pulsed during a 4-beat packet after beat 2: outputs go to 0 without waiting for clk. After release the state is IDLE and requester 0 wins first.
